instr_fetch_unit: RTL and testbench

- Front-end fetch stage for the 9-bit accumulator ISA.
- Drives the program counter into the instruction ROM and reassembles the decoded field outputs into a 9-bit word.
- Registers each word into an IF/ID pipeline register toward decode/execute.
- Handles stall, branch redirect/flush, halt detection and restart.

---
 rtl/instr_fetch_unit.sv | 127 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage for the 9-bit accumulator ISA: drives the ROM address and loads the IF/ID register.
// It handles stall, branch redirect/flush, halt drain and restart.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [8:0]  HALT_WORD = 9'h1B0,
    parameter logic [8:0]  NOP_WORD  = 9'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [15:0] pc_out,
    input  logic        rom_format,
    input  logic [3:0]  rom_opcode,
    input  logic        rom_sign,
    input  logic [2:0]  rom_operand,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        instr_valid,
    output logic [8:0]  instr_word,
    output logic [15:0] instr_pc,
    output logic        halted,
    output logic        done,
    output logic [15:0] issue_count,
    output logic [1:0]  fsm_state
);

    // Handshake: instr_valid marks a live IF/ID word and stall is the inverse of ready.
    // A word counts as issued on any cycle where instr_valid=1 and stall=0, unless a branch flushes it.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [15:0] pc_next, ipc_next, count_next, count_inc;
    logic [8:0]  word_next, rom_word;
    logic        valid_next, halted_next, done_next;

    assign rom_word  = {rom_format, rom_opcode, rom_sign, rom_operand};
    assign count_inc = (issue_count == 16'hFFFF) ? issue_count : issue_count + 16'd1;
    assign fsm_state = state;

    always_comb begin
        state_next  = state;
        pc_next     = pc_out;
        valid_next  = instr_valid;
        word_next   = instr_word;
        ipc_next    = instr_pc;
        halted_next = halted;
        done_next   = 1'b0;
        count_next  = issue_count;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                    pc_next    = RESET_PC;
                    count_next = 16'd0;
                end
            end
            FETCH: begin
                if (branch_taken) begin
                    pc_next    = branch_target;
                    valid_next = 1'b0;
                    word_next  = NOP_WORD;
                end else if (!stall) begin
                    word_next  = rom_word;
                    ipc_next   = pc_out;
                    valid_next = 1'b1;
                    if (instr_valid) count_next = count_inc;
                    // The halt word parks the PC on its own address.
                    if (rom_word == HALT_WORD) state_next = DRAIN;
                    else                       pc_next    = pc_out + 16'd1;
                end
            end
            DRAIN: begin
                if (branch_taken) begin
                    pc_next    = branch_target;
                    valid_next = 1'b0;
                    word_next  = NOP_WORD;
                    state_next = FETCH;
                end else if (!stall) begin
                    count_next  = count_inc;
                    valid_next  = 1'b0;
                    word_next   = NOP_WORD;
                    halted_next = 1'b1;
                    done_next   = 1'b1;
                    state_next  = HALT;
                end
            end
            HALT: begin
                if (start) begin
                    halted_next = 1'b0;
                    pc_next     = RESET_PC;
                    count_next  = 16'd0;
                    state_next  = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc_out      <= RESET_PC;
            instr_valid <= 1'b0;
            instr_word  <= NOP_WORD;
            instr_pc    <= 16'd0;
            halted      <= 1'b0;
            done        <= 1'b0;
            issue_count <= 16'd0;
        end else begin
            state       <= state_next;
            pc_out      <= pc_next;
            instr_valid <= valid_next;
            instr_word  <= word_next;
            instr_pc    <= ipc_next;
            halted      <= halted_next;
            done        <= done_next;
            issue_count <= count_next;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a constant-vector table, directed corner sequences,
// and randomized traffic checked against a cycle-level model built from the fetch rules.
module tb_instr_fetch_unit;

    localparam logic [8:0]  HALT = 9'h1B0;
    localparam logic [8:0]  NOP  = 9'h000;
    localparam logic [15:0] RPC  = 16'h0000;
    localparam logic [1:0]  PH_IDLE = 2'd0, PH_RUN = 2'd1, PH_DRAIN = 2'd2, PH_HALT = 2'd3;

    logic        clk = 1'b0;
    logic        reset, start, stall, branch_taken;
    logic [15:0] branch_target;
    logic [15:0] pc_out, instr_pc, issue_count;
    logic        rom_format, rom_sign;
    logic [3:0]  rom_opcode;
    logic [2:0]  rom_operand;
    logic        instr_valid, halted, done;
    logic [8:0]  instr_word;
    logic [1:0]  fsm_state;

    logic [8:0]  rom_mem [0:65535];
    int          errors = 0;
    int          checks = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    assign {rom_format, rom_opcode, rom_sign, rom_operand} = rom_mem[pc_out];

    instr_fetch_unit #(.RESET_PC(RPC), .HALT_WORD(HALT), .NOP_WORD(NOP)) dut (
        .clk(clk), .reset(reset), .start(start), .pc_out(pc_out),
        .rom_format(rom_format), .rom_opcode(rom_opcode), .rom_sign(rom_sign),
        .rom_operand(rom_operand), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .instr_valid(instr_valid), .instr_word(instr_word),
        .instr_pc(instr_pc), .halted(halted), .done(done), .issue_count(issue_count),
        .fsm_state(fsm_state)
    );

    // ---------------- reference model ----------------
    logic [1:0]  m_phase = PH_IDLE;
    logic [15:0] m_pc = RPC, m_ipc = 16'd0, m_cnt = 16'd0;
    logic        m_valid = 1'b0, m_halted = 1'b0, m_done = 1'b0;
    logic [8:0]  m_word = NOP;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic model_step(input logic r, st, stl, br, input logic [15:0] tgt);
        logic [8:0] w;
        w = rom_mem[m_pc];
        m_done = 1'b0;
        if (r) begin
            m_phase = PH_IDLE; m_pc = RPC; m_valid = 1'b0; m_word = NOP;
            m_ipc = 16'd0; m_halted = 1'b0; m_cnt = 16'd0;
        end else if (m_phase == PH_IDLE) begin
            if (st) begin m_phase = PH_RUN; m_pc = RPC; m_cnt = 16'd0; end
        end else if (m_phase == PH_RUN) begin
            if (br) begin
                m_pc = tgt; m_valid = 1'b0; m_word = NOP;
            end else if (!stl) begin
                if (m_valid) m_cnt = sat_inc(m_cnt);
                m_word = w; m_ipc = m_pc; m_valid = 1'b1;
                if (w == HALT) m_phase = PH_DRAIN;
                else m_pc = m_pc + 16'd1;
            end
        end else if (m_phase == PH_DRAIN) begin
            if (br) begin
                m_pc = tgt; m_valid = 1'b0; m_word = NOP; m_phase = PH_RUN;
            end else if (!stl) begin
                m_cnt = sat_inc(m_cnt); m_valid = 1'b0; m_word = NOP;
                m_halted = 1'b1; m_done = 1'b1; m_phase = PH_HALT;
            end
        end else begin
            if (st) begin m_halted = 1'b0; m_pc = RPC; m_cnt = 16'd0; m_phase = PH_RUN; end
        end
    endtask

    // ---------------- driver / scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, st, stl, br, input logic [15:0] tgt);
        @(negedge clk);
        reset = r; start = st; stall = stl; branch_taken = br; branch_target = tgt;
    endtask

    task automatic step(input string name, input logic r, st, stl, br, input logic [15:0] tgt);
        drive(r, st, stl, br, tgt);
        model_step(r, st, stl, br, tgt);
        @(posedge clk); #1;
        chk(name,
            {2'b0, pc_out, instr_valid, instr_word, instr_pc, halted, done, issue_count, fsm_state},
            {2'b0, m_pc, m_valid, m_word, m_ipc, m_halted, m_done, m_cnt, m_phase});
        if (done && instr_valid) chk("done_with_valid", 64'(done & instr_valid), 64'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic st, stl, br;
        logic [15:0] tgt;
        logic [15:0] pc; logic v; logic [8:0] w; logic [15:0] ipc;
        logic h, d; logic [15:0] cnt; logic [1:0] fs;
    } vec_t;

    vec_t tbl [0:10];
    int   unsigned sat_cycles;
    logic [8:0] tmp;
    logic r_i, st_i, stl_i, br_i;

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'd0;
        for (int a = 0; a < 65536; a++) begin
            tmp = 9'($urandom_range(0, 511));
            if (tmp == HALT) tmp = 9'h1B1;
            rom_mem[a] = tmp;
        end
        rom_mem[0] = 9'h000; rom_mem[1] = 9'h178; rom_mem[2] = 9'h100; rom_mem[3] = HALT;

        //          st stl br tgt       pc        v  w      ipc       h  d  cnt      fs
        tbl[0]  = '{0, 0, 0, 16'h0000, 16'h0000, 0, 9'h000, 16'h0000, 0, 0, 16'd0, PH_IDLE};
        tbl[1]  = '{1, 0, 0, 16'h0000, 16'h0000, 0, 9'h000, 16'h0000, 0, 0, 16'd0, PH_RUN};
        tbl[2]  = '{0, 0, 0, 16'h0000, 16'h0001, 1, 9'h000, 16'h0000, 0, 0, 16'd0, PH_RUN};
        tbl[3]  = '{0, 0, 0, 16'h0000, 16'h0002, 1, 9'h178, 16'h0001, 0, 0, 16'd1, PH_RUN};
        tbl[4]  = '{0, 0, 0, 16'h0000, 16'h0003, 1, 9'h100, 16'h0002, 0, 0, 16'd2, PH_RUN};
        tbl[5]  = '{0, 0, 0, 16'h0000, 16'h0003, 1, 9'h1B0, 16'h0003, 0, 0, 16'd3, PH_DRAIN};
        tbl[6]  = '{0, 0, 0, 16'h0000, 16'h0003, 0, 9'h000, 16'h0003, 1, 1, 16'd4, PH_HALT};
        tbl[7]  = '{0, 0, 0, 16'h0000, 16'h0003, 0, 9'h000, 16'h0003, 1, 0, 16'd4, PH_HALT};
        tbl[8]  = '{0, 1, 1, 16'h0040, 16'h0003, 0, 9'h000, 16'h0003, 1, 0, 16'd4, PH_HALT};
        tbl[9]  = '{1, 0, 0, 16'h0000, 16'h0000, 0, 9'h000, 16'h0003, 0, 0, 16'd0, PH_RUN};
        tbl[10] = '{0, 0, 0, 16'h0000, 16'h0001, 1, 9'h000, 16'h0000, 0, 0, 16'd0, PH_RUN};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state",
            {2'b0, pc_out, instr_valid, instr_word, instr_pc, halted, done, issue_count, fsm_state},
            {2'b0, 16'h0000, 1'b0, NOP, 16'h0000, 1'b0, 1'b0, 16'h0000, PH_IDLE});

        for (int i = 0; i <= 10; i++) begin
            drive(1'b0, tbl[i].st, tbl[i].stl, tbl[i].br, tbl[i].tgt);
            @(posedge clk); #1;
            chk($sformatf("table_row%0d", i),
                {2'b0, pc_out, instr_valid, instr_word, instr_pc, halted, done, issue_count, fsm_state},
                {2'b0, tbl[i].pc, tbl[i].v, tbl[i].w, tbl[i].ipc, tbl[i].h, tbl[i].d, tbl[i].cnt, tbl[i].fs});
        end

        // ---- stall hold at pc_out=5 ----
        rom_mem[3] = 9'h0A5;
        step("rst_a", 1, 0, 0, 0, 16'h0);
        step("start_a", 0, 1, 0, 0, 16'h0);
        for (int i = 0; i < 5; i++) step("run_a", 0, 0, 0, 0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            step("stall_hold", 0, 0, 1, 0, 16'h0);
            chk("stall_pc", 64'(pc_out), 64'h5);
            chk("stall_ipc", 64'(instr_pc), 64'h4);
            chk("stall_word", 64'(instr_word), 64'(rom_mem[4]));
        end
        step("resume1", 0, 0, 0, 0, 16'h0);
        chk("resume_ipc", 64'(instr_pc), 64'h5);
        step("resume2", 0, 0, 0, 0, 16'h0);
        chk("resume_ipc2", 64'(instr_pc), 64'h6);

        // ---- branch overriding stall ----
        step("branch_stall", 0, 0, 1, 1, 16'h0040);
        chk("br_bubble", {47'b0, instr_valid, pc_out}, {47'b0, 1'b0, 16'h0040});
        step("br_first", 0, 0, 0, 0, 16'h0);
        chk("br_target_valid", {47'b0, instr_valid, instr_pc}, {47'b0, 1'b1, 16'h0040});

        // ---- branch squashing a halt in drain ----
        rom_mem[16'h0042] = HALT;
        step("pre_halt", 0, 0, 0, 0, 16'h0);
        step("halt_in", 0, 0, 0, 0, 16'h0);
        chk("drain_state", 64'(fsm_state), 64'(PH_DRAIN));
        step("drain_branch", 0, 0, 0, 1, 16'h0080);
        chk("squash", {45'b0, halted, done, instr_valid, pc_out}, {45'b0, 3'b000, 16'h0080});
        step("after_squash", 0, 0, 0, 0, 16'h0);
        chk("squash_resume", {47'b0, instr_valid, instr_pc}, {47'b0, 1'b1, 16'h0080});
        rom_mem[16'h0042] = 9'h042;

        // ---- address wrap, start ignored in fetch, reset mid-run ----
        step("br_wrap", 0, 0, 0, 1, 16'hFFFE);
        step("wrap1", 0, 0, 0, 0, 16'h0);
        chk("wrap_pc1", 64'(pc_out), 64'hFFFF);
        step("wrap2", 0, 0, 0, 0, 16'h0);
        chk("wrap_pc2", 64'(pc_out), 64'h0000);
        step("wrap3", 0, 0, 0, 0, 16'h0);
        chk("wrap_pc3", {32'b0, pc_out, instr_pc}, {32'b0, 16'h0001, 16'h0000});
        step("start_in_fetch", 0, 1, 0, 0, 16'h0);
        chk("start_ignored", 64'(pc_out), 64'h0002);
        step("reset_mid", 1, 0, 0, 0, 16'h0);
        chk("reset_mid_vals",
            {2'b0, pc_out, instr_valid, instr_word, instr_pc, halted, done, issue_count, fsm_state},
            {2'b0, RPC, 1'b0, NOP, 16'h0000, 1'b0, 1'b0, 16'h0000, PH_IDLE});

        // ---- issue_count saturation over a long halt-free run ----
        step("sat_start", 0, 1, 0, 0, 16'h0);
        sat_cycles = 65545;
        for (int unsigned i = 0; i < sat_cycles; i++) step("sat_run", 0, 0, 0, 0, 16'h0);
        chk("count_saturated", 64'(issue_count), 64'hFFFF);

        // ---- randomized traffic ----
        for (int k = 0; k < 10; k++) rom_mem[$urandom_range(4, 255)] = HALT;
        step("rand_rst", 1, 0, 0, 0, 16'h0);
        for (int i = 0; i < 3000; i++) begin
            r_i   = ($urandom_range(0, 199) == 0);
            st_i  = (m_phase == PH_IDLE || m_phase == PH_HALT) ? ($urandom_range(0, 3) == 0)
                                                               : ($urandom_range(0, 29) == 0);
            stl_i = ($urandom_range(0, 3) == 0);
            br_i  = ($urandom_range(0, 9) == 0);
            step("random", r_i, st_i, stl_i, br_i, 16'($urandom_range(0, 255)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
